hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard and stall controller for the five-stage core, sitting beside the EXE-stage forwarding unit. It decides when forwarding cannot supply an operand: load-use with forwarding enabled, or any RAW against EXE/MEM with forwarding disabled. It then freezes the front end and injects a bubble into ID/EXE. It also freezes the whole pipeline while a multi-cycle SRAM access in MEM is outstanding, with a bounded wait and a sticky timeout flag, and counts stall cycles for performance reporting.

## Interface
- REG_W, 5: register index width
- MEM_TIMEOUT, 15: maximum freeze cycles per SRAM access (≥2)
- CNT_W, 16: stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- fwd_en  in  1  1 = forwarding unit active; 0 = stall on every RAW
- src1_ID, src2_ID  in  REG_W  source registers of the instruction in ID
- src2_check_ID  in  1  src2_ID is a real register read
- dest_EXE  in  REG_W  destination of the instruction in EXE
- wb_en_EXE  in  1  EXE instruction writes back
- mem_r_en_EXE  in  1  EXE instruction is a load
- dest_MEM  in  REG_W  destination of the instruction in MEM
- wb_en_MEM  in  1  MEM instruction writes back
- mem_req_MEM  in  1  MEM stage is issuing an SRAM access; held while frozen
- sram_ready  in  1  SRAM access completes this cycle
- stall_front  out  1  hold PC and IF/ID
- bubble_ID_EXE  out  1  load zero control into ID/EXE
- freeze_pipe  out  1  hold every pipeline register
- mem_timeout  out  1  sticky: an SRAM wait was abandoned
- stall_count  out  CNT_W  saturating count of stalled or frozen cycles

## Operation
- match1 = (src1_ID == d); match2 = src2_check_ID && (src2_ID == d). Register 0 is not excluded.
- hazard is asserted as follows:
  - fwd_en=1: mem_r_en_EXE && wb_en_EXE && match against dest_EXE.
  - fwd_en=0: (wb_en_EXE && match against dest_EXE) || (wb_en_MEM && match against dest_MEM).
- FSM states: RUN and MEM_WAIT. wait_cnt is ceil(log2(MEM_TIMEOUT+1)) bits wide.
- RUN:
  - mem_req_MEM && !sram_ready → freeze_pipe=1, go to MEM_WAIT, wait_cnt←1.
  - mem_req_MEM && sram_ready → no freeze, stay in RUN.
- MEM_WAIT (mem_req_MEM ignored):
  - sram_ready → freeze_pipe=0, go to RUN.
  - else if wait_cnt==MEM_TIMEOUT → freeze_pipe=0, mem_timeout←1, go to RUN.
  - else freeze_pipe=1, wait_cnt++.
- freeze_pipe has priority over hazard. stall_front = bubble_ID_EXE = hazard && !freeze_pipe, so a frozen ID instruction is never bubbled away.
- stall_count increments on every cycle with stall_front||freeze_pipe and saturates at all-ones.
- mem_timeout stays set until rst.

## Timing
- All outputs are combinational from the current state and inputs; state, wait_cnt, mem_timeout and stall_count are registered.
- The load-use stall lasts exactly 1 cycle when fwd_en=1. In the next cycle the load is in MEM and the forwarding unit covers it.
- fwd_en=0: a RAW on the EXE dest stalls 2 cycles; a RAW on the MEM dest stalls 1 cycle.
- SRAM wait freezes for a minimum of 1 cycle (request cycle) and a maximum of MEM_TIMEOUT cycles. Freeze drops in the cycle sram_ready is seen.
- mem_timeout becomes visible the cycle after the abandoning cycle.
- Reset values: state RUN, wait_cnt 0, mem_timeout 0, stall_count 0. The combinational outputs are therefore 0 unless inputs raise them.
- rst during MEM_WAIT forces RUN on the next edge and releases freeze.
- fwd_en changes take effect in the same cycle.

## Structure
- Shared core package holds the state enum {RUN, MEM_WAIT} and the REG_W constant, shared with the forwarding unit and register file.
- One sub-module, raw_match: combinational REG_W comparator producing match1/match2 for one destination. It is instantiated twice, for EXE and MEM.

## Test plan
- fwd_en=1, mem_r_en_EXE=1, wb_en_EXE=1, dest_EXE=3, src1_ID=3 → stall_front=bubble_ID_EXE=1 for 1 cycle; stall_count=1.
- fwd_en=1, same as above but src2_ID=3 with src2_check_ID=0, or a non-load in EXE → no stall.
- fwd_en=0, ADD r4 in EXE, ID reads r4, pipeline advancing → stall for 2 cycles (EXE then MEM match); stall_count=2.
- mem_req_MEM at cycle n, sram_ready at n+3 → freeze_pipe=1 for n..n+2 and 0 at n+3; RUN at n+4; mem_timeout=0. A simultaneous load-use hazard gives stall_front=0 while frozen.
- MEM_TIMEOUT=4, sram_ready never asserted → freeze for n..n+3, 0 at n+4; mem_timeout=1 from n+5 and held.
- rst asserted at n+2 of a wait → RUN, freeze_pipe=0, stall_count=0, mem_timeout=0 after the edge. A fresh request afterwards freezes normally.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared core definitions: pipeline register index width and the MEM-stage wait FSM states.
// Also imported by the forwarding unit and register file.
package hazard_stall_unit_pkg;

    localparam int CORE_REG_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_stall_unit_raw.sv
// Combinational RAW comparator of the two ID source registers against one destination.
// Zero latency; register 0 is deliberately not excluded.
module raw_match
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W = CORE_REG_W
) (
    input  logic [REG_W-1:0] i_src1,
    input  logic [REG_W-1:0] i_src2,
    input  logic             i_src2_check,
    input  logic [REG_W-1:0] i_dest,
    output logic             o_match1,
    output logic             o_match2
);

    assign o_match1 = (i_src1 == i_dest);
    assign o_match2 = i_src2_check && (i_src2 == i_dest);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller: load-use or no-forward RAW stalls, bounded SRAM freeze, stall counter.
// Outputs are combinational from registered state and current inputs; freeze overrides the hazard stall.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W       = CORE_REG_W,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             src2_check_ID,
    input  logic [REG_W-1:0] dest_EXE,
    input  logic             wb_en_EXE,
    input  logic             mem_r_en_EXE,
    input  logic [REG_W-1:0] dest_MEM,
    input  logic             wb_en_MEM,
    input  logic             mem_req_MEM,
    input  logic             sram_ready,
    output logic             stall_front,
    output logic             bubble_ID_EXE,
    output logic             freeze_pipe,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic [WCNT_W-1:0]  w_wait_cnt_nxt;
    logic               r_mem_timeout;
    logic               w_timeout_set;
    logic [CNT_W-1:0]   r_stall_count;
    logic               w_freeze;
    logic               w_hazard;
    logic               w_stall;
    logic               w_m1_exe, w_m2_exe, w_m1_mem, w_m2_mem;
    logic               w_raw_exe, w_raw_mem;

    raw_match #(.REG_W(REG_W)) u_match_exe (
        .i_src1       (src1_ID),
        .i_src2       (src2_ID),
        .i_src2_check (src2_check_ID),
        .i_dest       (dest_EXE),
        .o_match1     (w_m1_exe),
        .o_match2     (w_m2_exe)
    );

    raw_match #(.REG_W(REG_W)) u_match_mem (
        .i_src1       (src1_ID),
        .i_src2       (src2_ID),
        .i_src2_check (src2_check_ID),
        .i_dest       (dest_MEM),
        .o_match1     (w_m1_mem),
        .o_match2     (w_m2_mem)
    );

    assign w_raw_exe = wb_en_EXE && (w_m1_exe || w_m2_exe);
    assign w_raw_mem = wb_en_MEM && (w_m1_mem || w_m2_mem);

    // With forwarding only a load in EXE is unresolvable; without it any in-flight writer is.
    assign w_hazard = fwd_en ? (mem_r_en_EXE && w_raw_exe) : (w_raw_exe || w_raw_mem);
    assign w_stall  = w_hazard && !w_freeze;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_freeze       = 1'b0;
        w_timeout_set  = 1'b0;
        unique case (r_state)
            RUN: begin
                if (mem_req_MEM && !sram_ready) begin
                    w_freeze       = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (sram_ready) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WCNT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                    w_timeout_set  = 1'b1;
                end else begin
                    w_freeze       = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
            if ((w_stall || w_freeze) && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign stall_front   = w_stall;
    assign bubble_ID_EXE = w_stall;
    assign freeze_pipe   = w_freeze;
    assign mem_timeout   = r_mem_timeout;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then randomized traffic against a cycle model.
module tb_hazard_stall_unit;

    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fwd_en = 1'b0;
    logic [REG_W-1:0] src1_ID = '0, src2_ID = '0, dest_EXE = '0, dest_MEM = '0;
    logic             src2_check_ID = 1'b0, wb_en_EXE = 1'b0, mem_r_en_EXE = 1'b0;
    logic             wb_en_MEM = 1'b0, mem_req_MEM = 1'b0, sram_ready = 1'b0;
    logic             stall_front, bubble_ID_EXE, freeze_pipe, mem_timeout;
    logic [CNT_W-1:0] stall_count;

    hazard_stall_unit #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fwd_en        (fwd_en),
        .src1_ID       (src1_ID),
        .src2_ID       (src2_ID),
        .src2_check_ID (src2_check_ID),
        .dest_EXE      (dest_EXE),
        .wb_en_EXE     (wb_en_EXE),
        .mem_r_en_EXE  (mem_r_en_EXE),
        .dest_MEM      (dest_MEM),
        .wb_en_MEM     (wb_en_MEM),
        .mem_req_MEM   (mem_req_MEM),
        .sram_ready    (sram_ready),
        .stall_front   (stall_front),
        .bubble_ID_EXE (bubble_ID_EXE),
        .freeze_pipe   (freeze_pipe),
        .mem_timeout   (mem_timeout),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, fwd, s2c, wbe, mre, wbm, req, rdy;
        bit [4:0] s1, s2, de, dm;
    } stim_t;

    typedef struct {
        bit stall, bubble, freeze, tmo;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: is an SRAM access in flight, how many cycles it has frozen so far,
    // the sticky timeout flag, and the saturating stall count.
    bit m_wait   = 0;
    int m_frozen = 0;
    bit m_tmo    = 0;
    int m_cnt    = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.fwd = 1;
        s.s1 = 5'd30; s.s2 = 5'd31; s.de = 5'd10; s.dm = 5'd11;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   rd_e, rd_m, hz, fr;
        @(posedge clk);
        #1;
        rst = s.rst; fwd_en = s.fwd; src1_ID = s.s1; src2_ID = s.s2; src2_check_ID = s.s2c;
        dest_EXE = s.de; wb_en_EXE = s.wbe; mem_r_en_EXE = s.mre;
        dest_MEM = s.dm; wb_en_MEM = s.wbm; mem_req_MEM = s.req; sram_ready = s.rdy;

        rd_e = (s.s1 == s.de) || (s.s2c && s.s2 == s.de);
        rd_m = (s.s1 == s.dm) || (s.s2c && s.s2 == s.dm);
        hz   = s.fwd ? (s.mre && s.wbe && rd_e) : ((s.wbe && rd_e) || (s.wbm && rd_m));
        if (!m_wait) fr = s.req && !s.rdy;
        else         fr = !s.rdy && (m_frozen < MEM_TIMEOUT);
        e.freeze = fr;
        e.stall  = hz && !fr;
        e.bubble = e.stall;
        e.tmo    = m_tmo;
        e.cnt    = m_cnt;
        exp_q.push_back(e);

        if (s.rst) begin
            m_wait = 0; m_frozen = 0; m_tmo = 0; m_cnt = 0;
        end else begin
            if ((fr || e.stall) && m_cnt < CNT_MAX) m_cnt++;
            if (m_wait && !s.rdy && m_frozen >= MEM_TIMEOUT) m_tmo = 1;
            if (fr) begin
                m_frozen = m_wait ? m_frozen + 1 : 1;
                m_wait   = 1;
            end else begin
                m_wait   = 0;
                m_frozen = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_front",   int'(stall_front),   int'(e.stall));
                chk("bubble_ID_EXE", int'(bubble_ID_EXE), int'(e.bubble));
                chk("freeze_pipe",   int'(freeze_pipe),   int'(e.freeze));
                chk("mem_timeout",   int'(mem_timeout),   int'(e.tmo));
                chk("stall_count",   int'(stall_count),   e.cnt);
            end
        end
    end

    initial begin : driver
        stim_t s;
        repeat (3) @(posedge clk);

        s = idle(); s.rst = 1; drive(s);
        s = idle(); drive(s);

        // Load-use with forwarding: one stall, then the load sits in MEM.
        s = idle(); s.mre = 1; s.wbe = 1; s.de = 3; s.s1 = 3; drive(s);
        s = idle(); s.de = 0; s.wbm = 1; s.dm = 3; s.s1 = 3; drive(s);
        // src2 match ignored without src2_check; non-load in EXE does not stall.
        s = idle(); s.mre = 1; s.wbe = 1; s.de = 3; s.s2 = 3; s.s2c = 0; drive(s);
        s = idle(); s.wbe = 1; s.de = 3; s.s1 = 3; drive(s);
        s = idle(); s.mre = 1; s.wbe = 1; s.de = 0; s.s1 = 0; drive(s);

        // No forwarding: ADD r4 stalls twice (EXE then MEM).
        s = idle(); s.fwd = 0; s.wbe = 1; s.de = 4; s.s2 = 4; s.s2c = 1; drive(s);
        s = idle(); s.fwd = 0; s.de = 0; s.wbm = 1; s.dm = 4; s.s2 = 4; s.s2c = 1; drive(s);
        s = idle(); s.fwd = 0; drive(s);

        // SRAM ready on the fourth cycle, with a load-use hazard present throughout.
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.req = (i < 4); s.rdy = (i == 3);
            s.mre = 1; s.wbe = 1; s.de = 7; s.s1 = 7; drive(s);
        end
        s = idle(); drive(s);

        // Timeout: never ready; sticky flag afterwards.
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.req = (i < 5); drive(s);
        end

        // Reset in the middle of a wait, then a fresh request.
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.req = (i != 3) && (i < 6); s.rst = (i == 2); s.rdy = (i == 5); drive(s);
        end

        // Saturate the counter with a long hazard.
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            s = idle(); s.fwd = 0; s.wbe = 1; s.de = 2; s.s1 = 2; drive(s);
        end

        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 199) == 0);
            s.fwd = ($urandom_range(0, 3) != 0);
            s.s1  = 5'($urandom_range(0, 3));
            s.s2  = 5'($urandom_range(0, 3));
            s.s2c = 1'($urandom_range(0, 1));
            s.de  = 5'($urandom_range(0, 3));
            s.dm  = 5'($urandom_range(0, 3));
            s.wbe = 1'($urandom_range(0, 1));
            s.mre = 1'($urandom_range(0, 1));
            s.wbm = 1'($urandom_range(0, 1));
            s.req = ($urandom_range(0, 3) == 0);
            s.rdy = ($urandom_range(0, 3) == 0);
            drive(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
